dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning the byte-address width of the shared data memory (32 bytes).
REQ-002 The block SHALL have parameter RESET_LAST, default 1, meaning the port treated as last-granted at reset, so port 0 wins first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 p0_req, p1_req  input  1 each  word-access request; port 0 is the processor, port 1 is the loader/debug port.
REQ-006 p0_we, p1_we  input  1 each  1 = word write, 0 = word read.
REQ-007 p0_addr, p1_addr  input  ADDR_W each  byte address of the word's most-significant byte.
REQ-008 p0_wdata, p1_wdata  input  32 each  write data.
REQ-009 p0_ack, p1_ack  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  32  read data of the most recently completed read.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 gnt_id  output  1  port that owns the current transfer.
REQ-013 mem_addr  output  ADDR_W  byte address to memory.
REQ-014 mem_we  output  1  byte write enable.
REQ-015 mem_wdata  output  8  byte write data.
REQ-016 mem_rdata  input  8  combinational byte read data for mem_addr.

Function
REQ-017 The FSM SHALL have three states: IDLE -> XFER (request accepted) -> ACK (byte count 3 done) -> IDLE.
REQ-018 In IDLE with any request high, the block SHALL latch we, addr and wdata of the winning port, set gnt_id, and clear the byte counter.
REQ-019 Arbitration SHALL be round-robin: with both ports requesting, the port not granted last wins; with one port requesting, that port wins.
REQ-020 In XFER, mem_addr SHALL be (latched addr + count) mod 2^ADDR_W, so an access at 30 touches bytes 30, 31, 0, 1.
REQ-021 Byte order SHALL be big-endian: count k maps to bits [31-8k : 24-8k].
REQ-022 For writes, in XFER mem_we SHALL be 1 and mem_wdata SHALL be the selected latched byte; mem_we SHALL be 0 in every other state.
REQ-023 For reads, the block SHALL capture mem_rdata into byte lane k of rdata at the clock edge that ends count k.
REQ-024 XFER SHALL last exactly 4 cycles (count 0..3), then move to ACK.
REQ-025 In ACK, the block SHALL assert the gnt_id port's ack for exactly one cycle; rdata SHALL be stable from ACK until the next read's first capture.
REQ-026 Latency SHALL be fixed: ack is high in the 6th cycle counting the accepting cycle as cycle 1, and accepts SHALL be at least 6 cycles apart.
REQ-027 A requester SHALL hold req and its fields stable until its ack; the block SHALL ignore field changes after acceptance.
REQ-028 If a requester drops req mid-transfer, the block SHALL complete the transfer and still pulse ack.
REQ-029 A request arriving while busy SHALL wait; it SHALL be arbitrated only in IDLE.
REQ-030 Requests at misaligned addresses SHALL be accepted; no alignment check is made.

Reset
REQ-031 On assertion of rst_n = 0, the block SHALL immediately, independent of clk, force state IDLE, count 0, both acks 0, mem_we 0, busy 0, gnt_id 0, rdata 0, mem_addr 0, mem_wdata 0, and last-granted = RESET_LAST.
REQ-032 If reset is asserted mid-write, already-written bytes SHALL remain, no ack SHALL be issued, and no further bytes SHALL be written.
REQ-033 After reset is released, the first request SHALL be arbitrated on the next rising edge of clk.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/XFER/ACK), BYTES_PER_WORD = 4, NUM_PORTS = 2, and the port-ID type.
REQ-035 Round-robin selection SHALL be one sub-module, dmem_rr_pick (inputs: requests and last-granted; output: winner), which is purely combinational; the last-granted register stays in dmem_arbiter.

Verification
REQ-036 p0 write addr 4, data 0xDEADBEEF -> memory bytes 4..7 = DE AD BE EF, mem_we high exactly 4 cycles, p0_ack in cycle 6.
REQ-037 p1 read addr 4 after REQ-036 -> rdata = 0xDEADBEEF during p1_ack, p0_ack stays 0.
REQ-038 p0 and p1 request in the same cycle from reset, both held -> p0 served first, then p1; repeating both -> grants alternate p0, p1, p0, p1.
REQ-039 p0 write addr 30, data 0x11223344 -> bytes 30, 31, 0, 1 = 11, 22, 33, 44.
REQ-040 rst_n low during the 3rd XFER cycle of a p1 write 0xAABBCCDD at 8 -> bytes 8 and 9 written, bytes 10 and 11 unchanged, no ack, busy 0 at once, next request served normally.
REQ-041 p0 drops req after acceptance -> 4-byte transfer completes and p0_ack still pulses.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port word-to-byte data memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned NUM_PORTS      = 2;

  typedef logic port_id_t;

  // Big-endian lane select: byte k of a word is bits [31-8k : 24-8k].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports, status outputs and byte-wide memory bus of the arbiter.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
);
  logic              p0_req,   p1_req;
  logic              p0_we,    p1_we;
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_ack,   p1_ack;
  logic [31:0]       rdata;
  logic              busy;
  port_id_t          gnt_id;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_rdata,
    output p0_ack, p1_ack, rdata, busy, gnt_id, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_rdata,
    input  p0_ack, p1_ack, rdata, busy, gnt_id, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational two-port round-robin winner selection.
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_id_t             last_i,
  output port_id_t             win_o
);

  always_comb begin
    win_o = '0;
    if (req_i == 2'b11) begin
      win_o = ~last_i;
    end else if (req_i[1]) begin
      win_o = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising 32-bit word accesses into four big-endian byte
// accesses on a shared byte-wide memory, with round-robin port selection.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned RESET_LAST = 1
)(
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  port_id_t          last_q;
  port_id_t          gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ack0_q, ack1_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;

  port_id_t          win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  dmem_rr_pick u_pick (
    .req_i  ({bus.p1_req, bus.p0_req}),
    .last_i (last_q),
    .win_o  (win)
  );

  always_comb begin
    sel_we    = bus.p0_we;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (win) begin
      sel_we    = bus.p1_we;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  assign cnt_d = cnt_q + 2'd1;

  // Memory-side outputs are registered one byte ahead: the accept edge loads
  // byte 0, and each XFER edge loads the byte for the following count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= port_id_t'(RESET_LAST != 0);
      gnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            state_q     <= XFER;
            gnt_q       <= win;
            last_q      <= win;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            cnt_q       <= '0;
            mem_addr_q  <= sel_addr;
            mem_we_q    <= sel_we;
            mem_wdata_q <= word_byte(sel_wdata, 2'd0);
          end
        end
        XFER: begin
          if (!we_q) begin
            case (cnt_q)
              2'd0:    rdata_q[31:24] <= bus.mem_rdata;
              2'd1:    rdata_q[23:16] <= bus.mem_rdata;
              2'd2:    rdata_q[15:8]  <= bus.mem_rdata;
              default: rdata_q[7:0]   <= bus.mem_rdata;
            endcase
          end
          cnt_q       <= cnt_d;
          mem_addr_q  <= addr_q + ADDR_W'(cnt_d);
          mem_wdata_q <= word_byte(wdata_q, cnt_d);
          if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            state_q  <= ACK;
            mem_we_q <= 1'b0;
            ack0_q   <= (gnt_q == 1'b0);
            ack1_q   <= (gnt_q == 1'b1);
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt_id    = gnt_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected acks per port,
// a negedge monitor pops and compares whenever an ack appears.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned AW = 5;

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic fill_en;
  logic [7:0] mem [32];
  int cyc;
  int we_cnt;
  int n_cmp;
  int n_err;
  exp_t q0[$];
  exp_t q1[$];

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .RESET_LAST(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score(input bit port);
    exp_t e;
    bit empty;
    empty = port ? (q1.size() == 0) : (q0.size() == 0);
    if (empty) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ack: port %0d acked, expected no ack (t=%0t)", port, $time);
    end else begin
      if (port) e = q1.pop_front();
      else      e = q0.pop_front();
      check($sformatf("ack_cycle_p%0d", port), 32'(cyc), 32'(e.cyc));
      check($sformatf("gnt_id_p%0d", port), 32'(bus.gnt_id), 32'(port));
      if (!e.we) check($sformatf("rdata_p%0d", port), bus.rdata, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      we_cnt = we_cnt + int'(bus.mem_we);
      if (bus.p0_ack) score(1'b0);
      if (bus.p1_ack) score(1'b1);
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
    end
  endtask

  // lat: cycles from the issuing negedge to the negedge where ack is expected.
  task automatic issue(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input int lat, input bit drop);
    exp_t e;
    int we0;
    bit got;
    @(negedge clk);
    e.we = we; e.rdata = exp_rd; e.cyc = cyc + lat;
    if (port) q1.push_back(e);
    else      q0.push_back(e);
    we0 = we_cnt;
    drive(port, 1'b1, we, addr, wd);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (drop && i == 0) drive(port, 1'b0, ~we, ~addr, ~wd);
      if (port ? bus.p1_ack : bus.p0_ack) got = 1'b1;
    end
    drive(port, 1'b0, 1'b0, '0, '0);
    check($sformatf("ack_seen_p%0d", port), 32'(got), 32'd1);
    check($sformatf("we_cycles_p%0d", port), 32'(we_cnt - we0), we ? 32'd4 : 32'd0);
  endtask

  task automatic check_mem(input logic [AW-1:0] a, input logic [7:0] exp);
    check($sformatf("mem[%0d]", a), 32'(mem[a]), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    n_cmp = 0; n_err = 0; we_cnt = 0;
    fill_en = 1'b1;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    fill_en = 1'b0;
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_p0_ack",    32'(bus.p0_ack),    32'd0);
    check("rst_p1_ack",    32'(bus.p1_ack),    32'd0);
    check("rst_gnt_id",    32'(bus.gnt_id),    32'd0);
    check("rst_rdata",     bus.rdata,          32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst_n = 1'b1;

    // Simultaneous requests from reset, twice: p0, p1, p0, p1.
    repeat (2) begin
      fork
        issue(1'b0, 1'b0, 5'd4, '0, 32'h04050607, 5,  1'b0);
        issue(1'b1, 1'b0, 5'd0, '0, 32'h00010203, 11, 1'b0);
      join
    end

    issue(1'b0, 1'b1, 5'd4, 32'hDEADBEEF, '0, 5, 1'b0);
    check_mem(5'd4, 8'hDE); check_mem(5'd5, 8'hAD);
    check_mem(5'd6, 8'hBE); check_mem(5'd7, 8'hEF);
    issue(1'b1, 1'b0, 5'd4, '0, 32'hDEADBEEF, 5, 1'b0);

    issue(1'b0, 1'b1, 5'd30, 32'h11223344, '0, 5, 1'b0);
    check_mem(5'd30, 8'h11); check_mem(5'd31, 8'h22);
    check_mem(5'd0,  8'h33); check_mem(5'd1,  8'h44);
    issue(1'b1, 1'b0, 5'd30, '0, 32'h11223344, 5, 1'b0);

    issue(1'b0, 1'b1, 5'd12, 32'hCAFEF00D, '0, 5, 1'b1);
    check_mem(5'd12, 8'hCA); check_mem(5'd13, 8'hFE);
    check_mem(5'd14, 8'hF0); check_mem(5'd15, 8'h0D);

    // Reset during the third XFER cycle of a p1 write.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 5'd8, 32'hAABBCCDD);
    c = cyc;
    while (cyc < c + 3) @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    check("midrst_busy",   32'(bus.busy),   32'd0);
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_p1_ack", 32'(bus.p1_ack), 32'd0);
    check("midrst_rdata",  bus.rdata,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_mem(5'd8,  8'hAA); check_mem(5'd9,  8'hBB);
    check_mem(5'd10, 8'h0A); check_mem(5'd11, 8'h0B);
    issue(1'b0, 1'b0, 5'd8, '0, 32'hAABB0A0B, 5, 1'b0);

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
